// File: rtl/avs_mul_pkg.sv
// Shared constants for the avs_mul_array register block: register map,
// CTRL/STATUS bit positions and sequencer states.
package avs_mul_pkg;

    localparam logic [7:0] ADDR_OP_BASE  = 8'h00;
    localparam logic [7:0] ADDR_COEF     = 8'h10;
    localparam logic [7:0] ADDR_CTRL     = 8'h11;
    localparam logic [7:0] ADDR_RES_BASE = 8'h20;

    localparam int CTRL_START    = 0;
    localparam int CTRL_DONE_CLR = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ANY_OVF = 2;
    localparam int STAT_IRQ_EN  = 3;
    localparam int STAT_OVF_LSB = 8;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, STORE} state_t;

endpackage

// File: rtl/avs_mul_array_shift_add_mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// N cycles after load, 2N-bit product; done pulses in the last step cycle.
module shift_add_mul #(
    parameter int N = 32
) (
    input  logic           csi_clk,
    input  logic           rsi_reset_n,
    input  logic           load,
    input  logic [N-1:0]   mcand_in,
    input  logic [N-1:0]   mplier_in,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           run;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mcand_in};
            mplier <= mplier_in;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST)
                run <= 1'b0;
        end
    end

    assign done    = run && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/avs_mul_array.sv
// Avalon-MM block: CH operand registers each multiplied by one coefficient,
// channels processed in turn. Optional interrupt output under AVS_MUL_IRQ_EN.
module avs_mul_array
    import avs_mul_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           CH       = 4,
    parameter logic [N-1:0] COEF_RST = N'(3)
) (
    input  logic         csi_clk,
    input  logic         rsi_reset_n,
    input  logic [7:0]   avs_s0_address,
    input  logic         avs_s0_write,
    input  logic [N-1:0] avs_s0_writedata,
    input  logic         avs_s0_read,
    output logic [N-1:0] avs_s0_readdata
`ifdef AVS_MUL_IRQ_EN
    ,
    output logic         ins_irq
`endif
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);
`ifdef AVS_MUL_IRQ_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    logic [CH-1:0][N-1:0] op;
    logic [CH-1:0][N-1:0] res;
    logic [CH-1:0]        ovf;
    logic [N-1:0]         coef;
    logic                 busy;
    logic                 done;
    logic [CHW-1:0]       ch;
    state_t               state, state_nxt;
    logic                 mul_done;
    logic [2*N-1:0]       product;
`ifdef AVS_MUL_IRQ_EN
    logic                 irq_en;
`endif

    logic [7:0]        op_off, res_off;
    logic              op_hit, res_hit, ctrl_wr, start;
    logic [CTRL_W-1:0] wr_ctrl;
    logic [31:0]       status;
    logic [N-1:0]      rd_val;

    assign op_off  = avs_s0_address - ADDR_OP_BASE;
    assign res_off = avs_s0_address - ADDR_RES_BASE;
    assign op_hit  = op_off < 8'(CH);
    assign res_hit = res_off < 8'(CH);
    assign wr_ctrl = CTRL_W'(avs_s0_writedata);
    assign ctrl_wr = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign start   = ctrl_wr && wr_ctrl[CTRL_START] && !busy;

    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done;
        status[STAT_ANY_OVF] = |ovf;
`ifdef AVS_MUL_IRQ_EN
        status[STAT_IRQ_EN]  = irq_en;
`endif
        status[STAT_OVF_LSB +: CH] = ovf;
    end

    always_comb begin
        rd_val = '0;
        if (op_hit)
            rd_val = op[op_off[CHW-1:0]];
        else if (res_hit)
            rd_val = res[res_off[CHW-1:0]];
        else if (avs_s0_address == ADDR_COEF)
            rd_val = coef;
        else if (avs_s0_address == ADDR_CTRL)
            rd_val = status[N-1:0];
    end

    shift_add_mul #(.N(N)) u_mul (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .load        (state == LOAD),
        .mcand_in    (op[ch]),
        .mplier_in   (coef),
        .done        (mul_done),
        .product     (product)
    );

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = STORE;
            STORE:   state_nxt = (ch == LAST_CH) ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            avs_s0_readdata <= '0;
            op              <= '0;
            res             <= '0;
            ovf             <= '0;
            coef            <= COEF_RST;
            busy            <= 1'b0;
            done            <= 1'b0;
            ch              <= '0;
`ifdef AVS_MUL_IRQ_EN
            irq_en          <= 1'b0;
            ins_irq         <= 1'b0;
`endif
        end else begin
            avs_s0_readdata <= avs_s0_read ? rd_val : '0;

            // operands and coefficient are frozen while a run is in flight
            if (avs_s0_write && !busy) begin
                if (op_hit)
                    op[op_off[CHW-1:0]] <= avs_s0_writedata;
                if (avs_s0_address == ADDR_COEF)
                    coef <= avs_s0_writedata;
            end

            if (start) begin
                busy <= 1'b1;
                done <= 1'b0;
                ovf  <= '0;
                ch   <= '0;
            end else if (ctrl_wr && wr_ctrl[CTRL_DONE_CLR]) begin
                done <= 1'b0;
            end

            if (state == STORE) begin
                res[ch] <= product[N-1:0];
                ovf[ch] <= |product[2*N-1:N];
                if (ch == LAST_CH) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end

`ifdef AVS_MUL_IRQ_EN
            if (ctrl_wr)
                irq_en <= wr_ctrl[CTRL_IRQ_EN];
            ins_irq <= done & irq_en;
`endif
        end
    end

endmodule

// File: tb/tb_avs_mul_array.sv
// Randomised self-checking bench for avs_mul_array against a product model.
module tb_avs_mul_array;
    import avs_mul_pkg::*;

    localparam int N   = 32;
    localparam int CH  = 4;
    localparam int LAT = CH * (N + 2);

    logic         csi_clk = 1'b0;
    logic         rsi_reset_n = 1'b0;
    logic [7:0]   address = '0;
    logic         write = 1'b0;
    logic         read = 1'b0;
    logic [N-1:0] writedata = '0;
    logic [N-1:0] readdata;
`ifdef AVS_MUL_IRQ_EN
    logic         ins_irq;
`endif

    avs_mul_array #(.N(N), .CH(CH), .COEF_RST(N'(3))) dut (
        .csi_clk          (csi_clk),
        .rsi_reset_n      (rsi_reset_n),
        .avs_s0_address   (address),
        .avs_s0_write     (write),
        .avs_s0_writedata (writedata),
        .avs_s0_read      (read),
        .avs_s0_readdata  (readdata)
`ifdef AVS_MUL_IRQ_EN
        ,
        .ins_irq          (ins_irq)
`endif
    );

    always #5 csi_clk = ~csi_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [N-1:0] m_op [CH];
    logic [N-1:0] m_res[CH];
    logic         m_ovf[CH];
    logic [N-1:0] m_coef;
    logic         m_done;
    logic         m_irq_en;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_op[i] = '0; m_res[i] = '0; m_ovf[i] = 1'b0;
        end
        m_coef = 3; m_done = 1'b0; m_irq_en = 1'b0;
    endfunction

    function automatic void model_run();
        longint unsigned a, b, p;
        for (int i = 0; i < CH; i++) begin
            a = longint'(m_op[i]);
            b = longint'(m_coef);
            p = a * b;
            m_res[i] = p[N-1:0];
            m_ovf[i] = (p >> N) != 0;
        end
        m_done = 1'b1;
    endfunction

    function automatic logic [N-1:0] model_status();
        logic [N-1:0] s;
        s = '0;
        s[1] = m_done;
        for (int i = 0; i < CH; i++) begin
            s[8+i] = m_ovf[i];
            if (m_ovf[i]) s[2] = 1'b1;
        end
`ifdef AVS_MUL_IRQ_EN
        s[3] = m_irq_en;
`endif
        return s;
    endfunction

    task automatic bus_write(input logic [7:0] a, input logic [N-1:0] d);
        @(negedge csi_clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge csi_clk);
        write = 1'b0;
    endtask

    task automatic ctrl_write(input logic [N-1:0] d);
        bus_write(ADDR_CTRL, d);
        m_irq_en = d[2];
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [N-1:0] d);
        @(negedge csi_clk);
        address = a; read = 1'b1;
        @(negedge csi_clk);
        d = readdata; read = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        @(negedge csi_clk);
        address = ADDR_CTRL; read = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge csi_clk);
            if (readdata[1]) begin ok = 1'b1; break; end
        end
        read = 1'b0;
    endtask

    task automatic load_ops_coef();
        for (int i = 0; i < CH; i++) bus_write(ADDR_OP_BASE + 8'(i), m_op[i]);
        bus_write(ADDR_COEF, m_coef);
    endtask

    task automatic run_and_check(input string tag);
        bit ok;
        logic [N-1:0] d;
        ctrl_write(1);
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_timeout: done never seen", tag); end
        model_run();
        for (int i = 0; i < CH; i++) begin
            bus_read(ADDR_RES_BASE + 8'(i), d);
            n_checks++;
            if (d !== m_res[i]) begin
                n_fail++; $display("FAIL %s_res%0d: got %h expected %h", tag, i, d, m_res[i]);
            end
        end
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== model_status()) begin
            n_fail++; $display("FAIL %s_status: got %h expected %h", tag, d, model_status());
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] d;
        model_reset();
        repeat (3) @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge csi_clk);
            n_checks++;
            if (readdata !== '0) begin n_fail++; $display("FAIL idle_readdata: got %h expected 0", readdata); end
        end
        bus_read(ADDR_COEF, d);
        n_checks++;
        if (d !== N'(3)) begin n_fail++; $display("FAIL reset_coef: got %h expected 3", d); end
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_read(ADDR_RES_BASE, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL reset_res0: got %h expected 0", d); end
        bus_read(8'h05, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
    endtask

    task automatic test_rw_same_cycle();
        logic [N-1:0] d;
        @(negedge csi_clk);
        address = ADDR_COEF; writedata = 32'h55; write = 1'b1; read = 1'b1;
        @(negedge csi_clk);
        d = readdata; write = 1'b0; read = 1'b0;
        n_checks++;
        if (d !== m_coef) begin n_fail++; $display("FAIL rw_old_value: got %h expected %h", d, m_coef); end
        bus_read(ADDR_COEF, d);
        n_checks++;
        if (d !== N'(32'h55)) begin n_fail++; $display("FAIL rw_new_value: got %h expected 55", d); end
        bus_write(ADDR_COEF, m_coef);
    endtask

    task automatic test_basic();
        int first_done;
        m_op[0] = 5; m_op[1] = 7; m_op[2] = 0; m_op[3] = $urandom_range(1000, 1);
        m_coef = 3;
        load_ops_coef();
        ctrl_write(1);
        address = ADDR_CTRL; read = 1'b1;
        first_done = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(negedge csi_clk);
            if (k == 1) begin
                n_checks++;
                if (readdata[0] !== 1'b1) begin n_fail++; $display("FAIL busy_next_cycle: got %b expected 1", readdata[0]); end
            end
            if (readdata[1] === 1'b1 && first_done == 0) first_done = k;
        end
        read = 1'b0;
        n_checks++;
        if (first_done != LAT + 1) begin
            n_fail++; $display("FAIL done_latency: got %0d expected %0d", first_done, LAT + 1);
        end
        model_run();
        for (int i = 0; i < CH; i++) begin
            logic [N-1:0] d;
            bus_read(ADDR_RES_BASE + 8'(i), d);
            n_checks++;
            if (d !== m_res[i]) begin n_fail++; $display("FAIL basic_res%0d: got %h expected %h", i, d, m_res[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] d;
        m_op[0] = 32'h8000_0000; m_op[1] = 1;
        m_op[2] = $urandom; m_op[3] = $urandom_range(255, 0);
        m_coef = 2;
        load_ops_coef();
        run_and_check("ovf");
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d[8] !== 1'b1 || d[2] !== 1'b1 || d[9] !== 1'b0) begin
            n_fail++; $display("FAIL ovf_bits: got %h expected bit8=1 bit2=1 bit9=0", d);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < CH; i++)
                m_op[i] = (it == 1) ? '0 : N'($urandom);
            m_coef = (it == 0) ? '0 : (it == 2) ? N'($urandom_range(15, 1)) : N'($urandom);
            load_ops_coef();
            run_and_check($sformatf("rand%0d", it));
        end
    endtask

    task automatic test_busy();
        logic [N-1:0] d, old3, orig_op0, orig_coef;
        bit ok;
        old3 = m_res[3];
        for (int i = 0; i < CH; i++) m_op[i] = $urandom_range(65535, 1);
        m_coef = $urandom_range(65535, 1);
        orig_op0 = m_op[0]; orig_coef = m_coef;
        load_ops_coef();
        ctrl_write(1);
        bus_read(ADDR_RES_BASE + 8'd3, d);
        n_checks++;
        if (d !== old3) begin n_fail++; $display("FAIL busy_res3_old: got %h expected %h", d, old3); end
        bus_write(ADDR_OP_BASE, 9);
        bus_write(ADDR_COEF, 5);
        ctrl_write(1);
        ctrl_write(2);
        run_and_check("busy_ign");
        bus_read(ADDR_OP_BASE, d);
        n_checks++;
        if (d !== orig_op0) begin n_fail++; $display("FAIL busy_op0_kept: got %h expected %h", d, orig_op0); end
        bus_read(ADDR_COEF, d);
        n_checks++;
        if (d !== orig_coef) begin n_fail++; $display("FAIL busy_coef_kept: got %h expected %h", d, orig_coef); end
        // start plus done-clear in one write: start wins
        ctrl_write(3);
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d[1:0] !== 2'b01) begin n_fail++; $display("FAIL start_and_clear: got %b expected 01", d[1:0]); end
        wait_done(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL start_and_clear_timeout: done never seen"); end
        ctrl_write(2);
        m_done = 1'b0;
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== model_status()) begin n_fail++; $display("FAIL done_clear: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d;
        for (int i = 0; i < CH; i++) m_op[i] = $urandom_range(1000, 1);
        m_coef = 7;
        load_ops_coef();
        ctrl_write(1);
        address = ADDR_CTRL; read = 1'b1;
        repeat (20) @(negedge csi_clk);
        n_checks++;
        if (readdata !== N'(1)) begin n_fail++; $display("FAIL mid_busy_before_reset: got %h expected 1", readdata); end
        #2 rsi_reset_n = 1'b0;
        #1;
        n_checks++;
        if (readdata !== '0) begin n_fail++; $display("FAIL async_reset_readdata: got %h expected 0", readdata); end
        @(posedge csi_clk);
        @(negedge csi_clk);
        #2 rsi_reset_n = 1'b1;
        read = 1'b0;
        model_reset();
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL mid_reset_status: got %h expected 0", d); end
        bus_read(ADDR_RES_BASE, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL mid_reset_res0: got %h expected 0", d); end
        bus_read(ADDR_OP_BASE + 8'd1, d);
        n_checks++;
        if (d !== '0) begin n_fail++; $display("FAIL mid_reset_op1: got %h expected 0", d); end
        bus_read(ADDR_COEF, d);
        n_checks++;
        if (d !== N'(3)) begin n_fail++; $display("FAIL mid_reset_coef: got %h expected 3", d); end
    endtask

    task automatic test_irq();
        logic [N-1:0] d;
`ifdef AVS_MUL_IRQ_EN
        int first_done, first_irq;
        for (int i = 0; i < CH; i++) m_op[i] = $urandom_range(500, 1);
        m_coef = 11;
        load_ops_coef();
        ctrl_write(5);
        address = ADDR_CTRL; read = 1'b1;
        first_done = 0; first_irq = 0;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(negedge csi_clk);
            if (readdata[1] === 1'b1 && first_done == 0) first_done = k;
            if (ins_irq === 1'b1 && first_irq == 0) first_irq = k;
        end
        read = 1'b0;
        n_checks++;
        if (first_done != LAT + 1 || first_irq != first_done) begin
            n_fail++; $display("FAIL irq_rise: done at %0d irq at %0d expected both %0d", first_done, first_irq, LAT + 1);
        end
        model_run();
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== model_status()) begin n_fail++; $display("FAIL irq_status: got %h expected %h", d, model_status()); end
        ctrl_write(2);
        m_done = 1'b0;
        n_checks++;
        if (ins_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_one_cycle: got %b expected 1", ins_irq); end
        @(negedge csi_clk);
        n_checks++;
        if (ins_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b expected 0", ins_irq); end
`else
        ctrl_write(4);
        bus_read(ADDR_CTRL, d);
        n_checks++;
        if (d !== model_status()) begin n_fail++; $display("FAIL irq_bit_ignored: got %h expected %h", d, model_status()); end
`endif
    endtask

    initial begin
        test_reset();
        test_rw_same_cycle();
        test_basic();
        test_overflow();
        test_random();
        test_busy();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/avs_mul_array.md
Name: avs_mul_array

Overview:
- Avalon-MM slave; CH operand registers scaled by one programmable coefficient.
- Sequential shift-add multiplier, one coefficient bit per cycle.
- Busy/done/overflow status; results held in read-only registers.
- Generalises the fixed "A*3" register block: width, channel count and coefficient are parametrised, and computation is multi-cycle and started explicitly.

Parameters:
- N, 32, data/operand/result width (2..32).
- CH, 4, number of operand/result channels (1..16).
- COEF_RST, 3, coefficient register value after reset.

Ports:
- csi_clk  input  1  clock.
- rsi_reset_n  input  1  asynchronous active-low reset.
- avs_s0_address  input  8  register address.
- avs_s0_write  input  1  write strobe.
- avs_s0_writedata  input  N  write data.
- avs_s0_read  input  1  read strobe.
- avs_s0_readdata  output  N  registered read data.

Behaviour:
- Clocking/reset: one clock csi_clk. Reset rsi_reset_n is asynchronous, active-low.
  - Reset values: readdata=0, OP[i]=0, RES[i]=0, COEF=COEF_RST, busy=0, done=0, OVF[i]=0, state=IDLE.
- Register map:
  - 0x00..CH-1: OP[i], read/write.
  - 0x10: COEF, read/write.
  - 0x11: CTRL/STATUS.
    - Write: bit0=start, bit1=done clear (write-1-to-clear).
    - Read: bit0 busy, bit1 done, bit2 any-overflow, bits[8+CH-1:8] per-channel OVF; other bits 0.
  - 0x20..0x20+CH-1: RES[i], read-only.
  - Unmapped addresses: reads return 0; writes are ignored.
- Read timing:
  - readdata is registered, 1-cycle latency.
  - In a cycle with avs_s0_read=0, readdata <= 0.
  - No waitrequest.
- Write/read in the same cycle: both are performed. Read returns the pre-write value.
- State machine:
  - IDLE: start write with busy=0 → LOAD ch=0; in the same edge busy<=1, done<=0, OVF<=0.
  - LOAD: acc<=0, mcand<=OP[ch] zero-extended to 2N bits, mplier<=COEF, bit counter<=0 → MUL.
  - MUL: if mplier[0], acc<=acc+mcand; mcand<<=1; mplier>>=1. Run exactly N cycles → STORE.
  - STORE: RES[ch]<=acc[N-1:0]; OVF[ch]<=|acc[2N-1:N].
    - If ch==CH-1 → IDLE, busy<=0, done<=1.
    - Else ch+1 → LOAD.
- Latency:
  - Per channel: N+2 cycles.
  - busy reads 1 from the cycle after the start write; done is set CH*(N+2) cycles after the start edge.
- Arithmetic: unsigned, 2N-bit accumulator. RES holds the low N bits; OVF flags a nonzero upper half.
- While busy:
  - Writes to OP, COEF and start are ignored.
  - Done-clear is honoured.
  - Reads of RES return the latest stored value (not-yet-processed channels keep their old value).
- Start and done-clear in the same write: start wins, done=0.
- Reset asserted mid-operation: all state returns to reset values immediately; partial results are discarded.
- COEF=0: all RES=0, no OVF. OP=0: RES=0.

Optional Feature:
- Macro AVS_MUL_IRQ_EN.
- Defined:
  - Adds output port ins_irq (1 bit) and CTRL bit2 = irq_enable (read/write, reset 0; read back in STATUS bit3).
  - ins_irq = done & irq_enable, registered; reset value 0.
  - Clearing done deasserts ins_irq on the next cycle.
- Undefined:
  - No ins_irq port.
  - CTRL bit2 is ignored on write; STATUS bit3 reads 0.

Decomposition:
- Package avs_mul_pkg holds:
  - address constants ADDR_OP_BASE=8'h00, ADDR_COEF=8'h10, ADDR_CTRL=8'h11, ADDR_RES_BASE=8'h20;
  - CTRL/STATUS bit-index constants;
  - state enum state_t {IDLE, LOAD, MUL, STORE}.
- One sub-module: shift_add_mul.
  - Ports: load, operands, done pulse, 2N-bit product.
  - Implements LOAD/MUL internally.
  - Top level owns the register file, channel sequencing and the Avalon decode.

Test Plan:
- After reset, read 0x10 → 3; read 0x11 → 0; read 0x20 → 0; readdata=0 in every idle cycle.
- OP0=5, OP1=7, COEF=3, start → busy=1 next cycle; done after CH*(N+2)=136 cycles; RES0=15, RES1=21, OVF=0.
- N=32: OP0=0x8000_0000, COEF=2, start → RES0=0, STATUS bit8=1, bit2=1; RES1 (OP1=1) = 2, bit9=0.
- During busy, write OP0=9, COEF=5 and start → all ignored; results use the original values; after done, read OP0 → original value.
- Assert rsi_reset_n=0 for 1 cycle mid-MUL, asynchronous to the edge → readdata=0 and busy=0 immediately; RES/OP are cleared.
- With AVS_MUL_IRQ_EN: set irq_enable, start → ins_irq rises 1 cycle after done; write CTRL=0x2 → ins_irq falls 1 cycle later.
